// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - opcode encoding and opcode-class helpers for alu_exec_unit
package alu_exec_unit_pkg;

  typedef enum logic [5:0] {
    OP_ADD    = 6'h00,
    OP_SUB    = 6'h01,
    OP_SLL    = 6'h02,
    OP_SLT    = 6'h03,
    OP_SLTU   = 6'h04,
    OP_XOR    = 6'h05,
    OP_SRL    = 6'h06,
    OP_SRA    = 6'h07,
    OP_OR     = 6'h08,
    OP_AND    = 6'h09,
    OP_BEQ    = 6'h10,
    OP_BNE    = 6'h11,
    OP_BLT    = 6'h12,
    OP_BGE    = 6'h13,
    OP_BLTU   = 6'h14,
    OP_BGEU   = 6'h15,
    OP_JALR   = 6'h18,
    OP_LTYPE  = 6'h19,
    OP_STYPE  = 6'h1a,
    OP_MUL    = 6'h20,
    OP_MULH   = 6'h21,
    OP_MULHSU = 6'h22,
    OP_MULHU  = 6'h23
  } alu_op_e;

  // Loads and stores only need an effective address routed to the LSB.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LTYPE) || (op == OP_STYPE);
  endfunction

  // The four multiply opcodes share the 6'b1000xx prefix.
  function automatic logic is_mul_op(input logic [5:0] op);
    return op[5:2] == 4'b1000;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - RS issue, CDB, LSB and IF signal bundle for alu_exec_unit
interface alu_exec_unit_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4
);
  logic             RS_sgn;
  logic [5:0]       RS_opcode;
  logic [ROB_W-1:0] RS_ROB_name;
  logic [XLEN-1:0]  RS_lhs;
  logic [XLEN-1:0]  RS_rhs;
  logic             RS_ready;
  logic             CDB_sgn;
  logic [XLEN-1:0]  CDB_result;
  logic [ROB_W-1:0] CDB_ROB_name;
  logic             CDB_grant;
  logic             LSB_sgn;
  logic [XLEN-1:0]  LSB_result;
  logic [ROB_W-1:0] LSB_ROB_name;
  logic             IF_sgn;
  logic [XLEN-1:0]  IF_pc;

  modport master (
    output RS_sgn, RS_opcode, RS_ROB_name, RS_lhs, RS_rhs, CDB_grant,
    input  RS_ready, CDB_sgn, CDB_result, CDB_ROB_name,
    input  LSB_sgn, LSB_result, LSB_ROB_name, IF_sgn, IF_pc
  );

  modport slave (
    input  RS_sgn, RS_opcode, RS_ROB_name, RS_lhs, RS_rhs, CDB_grant,
    output RS_ready, CDB_sgn, CDB_result, CDB_ROB_name,
    output LSB_sgn, LSB_result, LSB_ROB_name, IF_sgn, IF_pc
  );
endinterface

// File: rtl/alu_out_fifo.sv
// rtl/alu_out_fifo.sv - in-order result queue feeding the CDB
module alu_out_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - integer execute unit with CDB queue; ALU_MUL_EN adds a multi-cycle multiplier
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_W     = 4,
  parameter int OUT_DEPTH = 2,
  parameter int MUL_LAT   = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  input logic             clr,
  alu_exec_unit_if.slave  bus
);
  localparam int SH_W = $clog2(XLEN);
  localparam int CW   = $clog2(OUT_DEPTH) + 1;

  logic [XLEN-1:0]       alu_res;
  logic [SH_W-1:0]       shamt;
  logic                  accept, push, pop, op_mem, op_jalr, op_mul;
  logic                  mul_busy, mul_done;
  logic [XLEN-1:0]       mul_res;
  logic [ROB_W-1:0]      mul_tag;
  logic [XLEN+ROB_W-1:0] push_data, head;
  logic [CW-1:0]         count;
  logic                  full, empty;

  assign shamt   = bus.RS_rhs[SH_W-1:0];
  assign op_mem  = is_mem_op(bus.RS_opcode);
  assign op_jalr = (bus.RS_opcode == OP_JALR);

  assign bus.RS_ready = rdy & ~rst & ~mul_busy & ~full;
  assign accept       = rdy & bus.RS_sgn & bus.RS_ready & ~clr;

  // Single-cycle result for every non-multiply opcode; unknown codes yield 0.
  always_comb begin
    alu_res = '0;
    case (bus.RS_opcode)
      OP_ADD:   alu_res = bus.RS_lhs + bus.RS_rhs;
      OP_SUB:   alu_res = bus.RS_lhs - bus.RS_rhs;
      OP_SLL:   alu_res = bus.RS_lhs << shamt;
      OP_SLT:   alu_res = XLEN'($signed(bus.RS_lhs) < $signed(bus.RS_rhs));
      OP_SLTU:  alu_res = XLEN'(bus.RS_lhs < bus.RS_rhs);
      OP_XOR:   alu_res = bus.RS_lhs ^ bus.RS_rhs;
      OP_SRL:   alu_res = bus.RS_lhs >> shamt;
      OP_SRA:   alu_res = $signed(bus.RS_lhs) >>> shamt;
      OP_OR:    alu_res = bus.RS_lhs | bus.RS_rhs;
      OP_AND:   alu_res = bus.RS_lhs & bus.RS_rhs;
      OP_BEQ:   alu_res = XLEN'(bus.RS_lhs == bus.RS_rhs);
      OP_BNE:   alu_res = XLEN'(bus.RS_lhs != bus.RS_rhs);
      OP_BLT:   alu_res = XLEN'($signed(bus.RS_lhs) < $signed(bus.RS_rhs));
      OP_BGE:   alu_res = XLEN'($signed(bus.RS_lhs) >= $signed(bus.RS_rhs));
      OP_BLTU:  alu_res = XLEN'(bus.RS_lhs < bus.RS_rhs);
      OP_BGEU:  alu_res = XLEN'(bus.RS_lhs >= bus.RS_rhs);
      OP_JALR:  alu_res = (bus.RS_lhs + bus.RS_rhs) & ~XLEN'(1);
      OP_LTYPE: alu_res = bus.RS_lhs + bus.RS_rhs;
      OP_STYPE: alu_res = bus.RS_lhs + bus.RS_rhs;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int MC_W = $clog2(MUL_LAT + 1);
  logic [MC_W-1:0]   mul_cnt;
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, product;

  assign op_mul  = is_mul_op(bus.RS_opcode);
  assign a_sgn   = (bus.RS_opcode == OP_MULH) || (bus.RS_opcode == OP_MULHSU);
  assign b_sgn   = (bus.RS_opcode == OP_MULH);
  assign a_ext   = {{XLEN{a_sgn & bus.RS_lhs[XLEN-1]}}, bus.RS_lhs};
  assign b_ext   = {{XLEN{b_sgn & bus.RS_rhs[XLEN-1]}}, bus.RS_rhs};
  assign product = a_ext * b_ext;
  assign mul_done = mul_busy & rdy & ~clr & (mul_cnt == '0);

  // Capture the product at accept, then hold the unit busy for MUL_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_busy <= 1'b0;
      mul_cnt  <= '0;
      mul_res  <= '0;
      mul_tag  <= '0;
    end else if (clr) begin
      mul_busy <= 1'b0;
      mul_cnt  <= '0;
    end else if (rdy) begin
      if (accept && op_mul) begin
        mul_busy <= 1'b1;
        mul_cnt  <= MC_W'(MUL_LAT - 1);
        mul_res  <= (bus.RS_opcode == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        mul_tag  <= bus.RS_ROB_name;
      end else if (mul_busy) begin
        if (mul_cnt == '0) mul_busy <= 1'b0;
        else               mul_cnt  <= mul_cnt - MC_W'(1);
      end
    end
  end
`else
  assign op_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_tag  = '0;
`endif

  assign push      = (accept & ~op_mem & ~op_mul) | mul_done;
  assign push_data = mul_done ? {mul_tag, mul_res} : {bus.RS_ROB_name, alu_res};
  assign pop       = rdy & bus.CDB_grant & ~empty & ~clr;

  alu_out_fifo #(
    .WIDTH(XLEN + ROB_W),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clr      (clr),
    .push_data(push_data),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign bus.CDB_sgn = (count != '0);
  assign {bus.CDB_ROB_name, bus.CDB_result} = head;

  // One-cycle LSB address and JALR redirect pulses; data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.LSB_sgn      <= 1'b0;
      bus.LSB_result   <= '0;
      bus.LSB_ROB_name <= '0;
      bus.IF_sgn       <= 1'b0;
      bus.IF_pc        <= '0;
    end else if (clr || !rdy) begin
      bus.LSB_sgn <= 1'b0;
      bus.IF_sgn  <= 1'b0;
    end else begin
      bus.LSB_sgn <= accept & op_mem;
      bus.IF_sgn  <= accept & op_jalr;
      if (accept && op_mem) begin
        bus.LSB_result   <= alu_res;
        bus.LSB_ROB_name <= bus.RS_ROB_name;
      end
      if (accept && op_jalr) bus.IF_pc <= alu_res;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed bench for alu_exec_unit against a queue model
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int DEPTH   = 2;
  localparam int MUL_LAT = 3;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic clr = 1'b0;

  alu_exec_unit_if #(.XLEN(32), .ROB_W(4)) bus ();

  alu_exec_unit #(
    .XLEN(32), .ROB_W(4), .OUT_DEPTH(DEPTH), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  ent_t        mq[$];
  int          mul_left = 0;
  ent_t        mul_ent;
  bit          e_lsb = 0;
  logic [31:0] e_lsb_res = '0;
  logic [3:0]  e_lsb_tag = '0;
  bit          e_if = 0;
  logic [31:0] e_if_pc = '0;

  logic [5:0] ops [0:22] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                             OP_OR, OP_AND, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
                             OP_JALR, OP_LTYPE, OP_STYPE, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_mul(input logic [5:0] op);
`ifdef ALU_MUL_EN
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_compute(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_ADD, OP_LTYPE, OP_STYPE: return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'(sa >>> b[4:0]);
      OP_SLT, OP_BLT: return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_BLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_BGE:  return (sa >= sb) ? 32'd1 : 32'd0;
      OP_BGEU: return (a >= b) ? 32'd1 : 32'd0;
      OP_BEQ:  return (a == b) ? 32'd1 : 32'd0;
      OP_BNE:  return (a != b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_JALR: return (a + b) & 32'hFFFF_FFFE;
`ifdef ALU_MUL_EN
      OP_MUL:    begin p = 64'(a) * 64'(b);          return p[31:0];  end
      OP_MULH:   begin p = sa * sb;                  return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      OP_MULHU:  begin p = 64'(a) * 64'(b);          return p[63:32]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model, return just after posedge.
  task automatic step(input bit r, input bit c, input bit s, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input bit g);
    bit exp_rdy, acc;
    ent_t e;
    @(negedge clk);
    rdy = r; clr = c; bus.RS_sgn = s; bus.RS_opcode = op;
    bus.RS_lhs = a; bus.RS_rhs = b; bus.RS_ROB_name = t; bus.CDB_grant = g;
    #1;
    exp_rdy = r && (mul_left == 0) && (mq.size() < DEPTH);
    check("rs_ready", 64'(bus.RS_ready), 64'(exp_rdy));
    check("cdb_sgn", 64'(bus.CDB_sgn), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("cdb_result", 64'(bus.CDB_result), 64'(mq[0].res));
      check("cdb_tag", 64'(bus.CDB_ROB_name), 64'(mq[0].tag));
    end
    check("lsb_sgn", 64'(bus.LSB_sgn), 64'(e_lsb));
    if (e_lsb) begin
      check("lsb_result", 64'(bus.LSB_result), 64'(e_lsb_res));
      check("lsb_tag", 64'(bus.LSB_ROB_name), 64'(e_lsb_tag));
    end
    check("if_sgn", 64'(bus.IF_sgn), 64'(e_if));
    if (e_if) check("if_pc", 64'(bus.IF_pc), 64'(e_if_pc));
    acc = r && s && exp_rdy && !c;
    e_lsb = 0;
    e_if  = 0;
    if (c) begin
      mq.delete();
      mul_left = 0;
    end else if (r) begin
      if (g && mq.size() > 0) void'(mq.pop_front());
      if (mul_left > 0) begin
        if (mul_left == 1) mq.push_back(mul_ent);
        mul_left--;
      end
      if (acc) begin
        e.res = ref_compute(op, a, b);
        e.tag = t;
        if (op == OP_LTYPE || op == OP_STYPE) begin
          e_lsb = 1; e_lsb_res = e.res; e_lsb_tag = t;
        end else if (ref_mul(op)) begin
          mul_ent = e; mul_left = MUL_LAT;
        end else begin
          mq.push_back(e);
          if (op == OP_JALR) begin e_if = 1; e_if_pc = e.res; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit g);
    step(1, 0, 0, OP_ADD, 32'd0, 32'd0, 4'd0, g);
  endtask

  initial begin
    bus.RS_sgn = 0; bus.RS_opcode = '0; bus.RS_ROB_name = '0;
    bus.RS_lhs = '0; bus.RS_rhs = '0; bus.CDB_grant = 0;
    rdy = 1;
    #12;
    check("rst_ready", 64'(bus.RS_ready), 64'd0);
    check("rst_cdb_sgn", 64'(bus.CDB_sgn), 64'd0);
    check("rst_lsb_sgn", 64'(bus.LSB_sgn), 64'd0);
    check("rst_if_sgn", 64'(bus.IF_sgn), 64'd0);
    check("rst_data", {bus.CDB_result, bus.IF_pc}, 64'd0);
    check("rst_lsb_data", 64'(bus.LSB_result), 64'd0);
    @(negedge clk);
    rst = 0;

    // ADD with immediate grant: one cycle on the CDB, then gone.
    step(1, 0, 1, OP_ADD, 32'd7, 32'd5, 4'd3, 1);
    check("add_sgn", 64'(bus.CDB_sgn), 64'd1);
    check("add_res", 64'(bus.CDB_result), 64'd12);
    check("add_tag", 64'(bus.CDB_ROB_name), 64'd3);
    idle(1);
    check("add_gone", 64'(bus.CDB_sgn), 64'd0);

    // Fill the queue without grants, then drain.
    step(1, 0, 1, OP_SUB, 32'd10, 32'd3, 4'd1, 0);
    step(1, 0, 1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2, 0);
    check("full_ready", 64'(bus.RS_ready), 64'd0);
    check("full_head", {28'd0, bus.CDB_ROB_name, bus.CDB_result}, {28'd0, 4'd1, 32'd7});
    idle(1);
    check("second_head", {28'd0, bus.CDB_ROB_name, bus.CDB_result}, {28'd0, 4'd2, 32'd1});
    idle(1);
    check("drained_ready", 64'(bus.RS_ready), 64'd1);

    // JALR redirect plus CDB delivery.
    step(1, 0, 1, OP_JALR, 32'h1001, 32'd4, 4'd5, 1);
    check("jalr_if", {31'd0, bus.IF_sgn, bus.IF_pc}, {31'd0, 1'b1, 32'h1004});
    check("jalr_cdb", {28'd0, bus.CDB_ROB_name, bus.CDB_result}, {28'd0, 4'd5, 32'h1004});
    idle(1);

    // Store address goes only to the LSB.
    step(1, 0, 1, OP_STYPE, 32'h100, 32'hFFFF_FFFC, 4'd6, 1);
    check("st_lsb", {27'd0, bus.LSB_sgn, bus.LSB_ROB_name, bus.LSB_result}, {27'd0, 1'b1, 4'd6, 32'hFC});
    check("st_no_cdb", 64'(bus.CDB_sgn), 64'd0);
    idle(1);

    // Flush with a simultaneous issue: everything is dropped.
    step(1, 0, 1, OP_OR, 32'hF0, 32'h0F, 4'd8, 0);
    step(1, 0, 1, OP_XOR, 32'hFF, 32'h0F, 4'd9, 0);
    step(1, 1, 1, OP_ADD, 32'd1, 32'd1, 4'd7, 0);
    check("clr_cdb", 64'(bus.CDB_sgn), 64'd0);
    check("clr_count", 64'(dut.u_fifo.count), 64'd0);
    idle(1);
    idle(1);

    // Pause holds the head even with a grant.
    step(1, 0, 1, OP_SLL, 32'd3, 32'd4, 4'd10, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, OP_ADD, 32'd0, 32'd0, 4'd0, 1);
      check("pause_hold", {27'd0, bus.CDB_sgn, bus.CDB_ROB_name, bus.CDB_result}, {27'd0, 1'b1, 4'd10, 32'd48});
    end
    idle(1);
    check("pause_pop", 64'(bus.CDB_sgn), 64'd0);

`ifdef ALU_MUL_EN
    step(1, 0, 1, OP_MULH, 32'h8000_0000, 32'd2, 4'd4, 0);
    for (int i = 0; i < MUL_LAT; i++) begin
      check("mul_busy_ready", 64'(bus.RS_ready), 64'd0);
      idle(0);
    end
    check("mulh_cdb", {27'd0, bus.CDB_sgn, bus.CDB_ROB_name, bus.CDB_result}, {27'd0, 1'b1, 4'd4, 32'hFFFF_FFFF});
    idle(1);
    step(1, 0, 1, OP_MUL, 32'd6, 32'd7, 4'd11, 1);
    idle(1);
    @(negedge clk);
    rst = 1;
    #1;
    check("mrst_ready", 64'(bus.RS_ready), 64'd0);
    check("mrst_cdb", 64'(bus.CDB_sgn), 64'd0);
    mq.delete(); mul_left = 0; e_lsb = 0; e_if = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < MUL_LAT + 2; i++) idle(1);
`else
    step(1, 0, 1, OP_MULH, 32'h8000_0000, 32'd2, 4'd4, 1);
    check("mul_off_cdb", {27'd0, bus.CDB_sgn, bus.CDB_ROB_name, bus.CDB_result}, {27'd0, 1'b1, 4'd4, 32'd0});
    idle(1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 22)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
           op, a, b, 4'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
